full_adder: RTL and testbench

FULL_ADDER -- requirements
Module: full_adder

---
 rtl/full_adder_pkg.sv | 28 ++
 rtl/full_adder_fa_cell.sv | 14 +
 rtl/full_adder.sv | 59 +++++
 tb/tb_full_adder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/full_adder_pkg.sv
// Shared constants and types for the full adder slice.
// Holds the bit counter width, its saturation value and the register bundle.
package full_adder_pkg;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

    typedef struct packed {
        logic             sum;
        logic             cout;
        logic             vld;
        logic [CNT_W-1:0] cnt;
    } fa_regs_t;

    localparam fa_regs_t REGS_RST = '{
        sum:  1'b0,
        cout: 1'b0,
        vld:  1'b0,
        cnt:  '0
    };

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/full_adder_fa_cell.sv
// Pure combinational one-bit full adder cell.
// Sum is the parity of the inputs, carry is their majority.
module fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);

endmodule

// File: rtl/full_adder.sv
// Full adder with registered outputs and a bit-serial carry loop.
// cout_q doubles as the serial carry register; bit_cnt counts serial bits.
module full_adder
    import full_adder_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             cin,
    input  logic             serial_en,
    input  logic             in_valid,
    output logic             sum,
    output logic             cout,
    output logic             sum_q,
    output logic             cout_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] bit_cnt
);

    fa_regs_t regs_q;
    fa_regs_t regs_d;
    logic     carry_sel;

    assign carry_sel = serial_en ? regs_q.cout : cin;

    fa_cell u_cell (
        .a_i  (a),
        .b_i  (b),
        .ci_i (carry_sel),
        .s_o  (sum),
        .co_o (cout)
    );

    always_comb begin
        regs_d     = regs_q;
        regs_d.vld = in_valid;
        if (in_valid) begin
            regs_d.sum  = sum;
            regs_d.cout = cout;
            // A non-serial accepted cycle restarts the serial bit count.
            regs_d.cnt  = serial_en ? sat_inc(regs_q.cnt) : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= REGS_RST;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign sum_q     = regs_q.sum;
    assign cout_q    = regs_q.cout;
    assign out_valid = regs_q.vld;
    assign bit_cnt   = regs_q.cnt;

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder using an arithmetic reference model.
// Directed steps plus randomized traffic and serial word additions.
module tb_full_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       a, b, cin, serial_en, in_valid;
    logic       sum, cout, sum_q, cout_q, out_valid;
    logic [7:0] bit_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference state: what the registered outputs should hold.
    logic m_sum, m_cout, m_vld;
    int   m_cnt;

    full_adder dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .serial_en (serial_en),
        .in_valid  (in_valid),
        .sum       (sum),
        .cout      (cout),
        .sum_q     (sum_q),
        .cout_q    (cout_q),
        .out_valid (out_valid),
        .bit_cnt   (bit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] req);
        checks++;
        assert (obs === req) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_sum_q"}, 16'(sum_q), 16'(m_sum));
        chk({tag, "_cout_q"}, 16'(cout_q), 16'(m_cout));
        chk({tag, "_out_valid"}, 16'(out_valid), 16'(m_vld));
        chk({tag, "_bit_cnt"}, 16'(bit_cnt), 16'(m_cnt));
    endtask

    task automatic step(input logic ai, input logic bi, input logic ci,
                        input logic ser, input logic vld,
                        input string tag);
        int tot;
        @(negedge clk);
        a = ai; b = bi; cin = ci; serial_en = ser; in_valid = vld;
        #1;
        tot = int'(ai) + int'(bi) + int'(ser ? m_cout : ci);
        chk({tag, "_sum"}, 16'(sum), 16'(tot % 2));
        chk({tag, "_cout"}, 16'(cout), 16'(tot / 2));
        @(posedge clk);
        if (vld) begin
            m_sum  = 1'(tot % 2);
            m_cout = 1'(tot / 2);
            m_vld  = 1'b1;
            m_cnt  = ser ? ((m_cnt < 255) ? m_cnt + 1 : 255) : 0;
        end else begin
            m_vld = 1'b0;
        end
        #1;
        chk_regs(tag);
    endtask

    task automatic add_word(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] res;
        logic [8:0] want;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "seed");
        for (int k = 0; k < 8; k++) begin
            step(x[k], y[k], 1'b0, 1'b1, 1'b1, "ser_word");
            res[k] = sum_q;
        end
        want = 9'(x) + 9'(y);
        chk("word_result", 16'({cout_q, res}), 16'(want));
        chk("word_cnt", 16'(bit_cnt), 16'd8);
    endtask

    logic [1:0] tbl [8];
    logic [3:0] ser_sums;
    logic [7:0] rx, ry;

    initial begin
        tbl = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
        rst = 1'b1;
        a = 1'b0; b = 1'b0; cin = 1'b0; serial_en = 1'b0; in_valid = 1'b0;
        m_sum = 1'b0; m_cout = 1'b0; m_vld = 1'b0; m_cnt = 0;
        #1;
        chk_regs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Truth table, purely combinational.
        for (int i = 0; i < 8; i++) begin
            {a, b, cin} = 3'(i);
            #1;
            chk("tt", 16'({sum, cout}), 16'(tbl[i]));
            #4;
        end

        // One-cycle latency.
        @(negedge clk);
        a = 1'b1; b = 1'b1; cin = 1'b1; in_valid = 1'b1;
        #1;
        chk("lat_pre_vld", 16'(out_valid), 16'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "lat");

        // 0xB + 0x6 serially.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "seed4");
        for (int k = 0; k < 4; k++) begin
            rx = 8'hB; ry = 8'h6;
            step(rx[k], ry[k], 1'b0, 1'b1, 1'b1, "ser4");
            ser_sums[k] = sum_q;
        end
        chk("ser4_sums", 16'(ser_sums), 16'h1);
        chk("ser4_cout", 16'(cout_q), 16'd1);
        chk("ser4_cnt", 16'(bit_cnt), 16'd4);

        // Hold with in_valid low.
        for (int k = 0; k < 4; k++)
            step(1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'b0, "hold");
        chk("hold_sum_q", 16'(sum_q), 16'd0);
        chk("hold_cout_q", 16'(cout_q), 16'd1);

        // Asynchronous reset in the middle of a serial run.
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "pre_rst");
        @(negedge clk);
        in_valid = 1'b0; serial_en = 1'b1; a = 1'b1; b = 1'b0;
        rst = 1'b1;
        m_sum = 1'b0; m_cout = 1'b0; m_vld = 1'b0; m_cnt = 0;
        #1;
        chk_regs("async_rst");
        chk("rst_comb_sum", 16'(sum), 16'd1);
        chk("rst_comb_cout", 16'(cout), 16'd0);
        #1;
        rst = 1'b0;
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "post_rst");
        chk("post_rst_sum_q", 16'(sum_q), 16'd0);
        chk("post_rst_cout_q", 16'(cout_q), 16'd1);

        // Randomized mixed traffic.
        for (int k = 0; k < 120; k++)
            step(1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom_range(0, 3) != 0), "rand");

        // Random serial word additions.
        for (int k = 0; k < 6; k++)
            add_word(8'($urandom), 8'($urandom));

        // Counter saturation.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "sat_seed");
        for (int k = 0; k < 300; k++)
            step(1'($urandom), 1'($urandom), 1'($urandom),
                 1'b1, 1'b1, "sat");
        chk("sat_cnt", 16'(bit_cnt), 16'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
